// File: rtl/serv_csr_sched.sv
// serv_csr_sched: arbitrates the bit-serial serv_csr datapath between a
// synchronous trap, a pending timer interrupt and a CSR/mret instruction.
// Each grant runs one full 32-bit serial pass of N = 32/W cycles, then a
// single DONE cycle that pulses the matching ack.
//
// state | meaning
// IDLE  | waiting; requests sampled here, one per edge, by priority
// RUN   | serial pass in progress, cnt steps by W from 0 to 32-W
// DONE  | one cycle; pulses o_trap_ack or o_csr_ack, then back to IDLE
module serv_csr_sched #(
  parameter int W = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_trap_req,
  input  logic       i_irq_pending,
  input  logic       i_csr_req,
  input  logic [1:0] i_csr_sel,
  input  logic       i_mret,
  output logic       o_trap_ack,
  output logic       o_csr_ack,
  output logic       o_busy,
  output logic       o_en,
  output logic       o_cnt0to3,
  output logic       o_cnt3,
  output logic       o_cnt7,
  output logic       o_cnt11,
  output logic       o_cnt12,
  output logic       o_cnt_done,
  output logic       o_mstatus_en,
  output logic       o_mie_en,
  output logic       o_mcause_en,
  output logic       o_rf_csr_en,
  output logic       o_trap,
  output logic       o_irq,
  output logic       o_mret
);

  // cnt is always a multiple of W, so a strobe for bit k is active when the
  // W-wide block holding cnt matches the block holding k.
  localparam int         SH   = (W == 4) ? 2 : ((W == 2) ? 1 : 0);
  localparam logic [4:0] STEP = 5'(W);
  localparam logic [4:0] LAST = 5'(32 - W);
  localparam logic [4:0] B3   = 5'(3 >> SH);
  localparam logic [4:0] B7   = 5'(7 >> SH);
  localparam logic [4:0] B11  = 5'(11 >> SH);
  localparam logic [4:0] B12  = 5'(12 >> SH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state;
  logic [4:0] cnt;
  logic [4:0] cnt_blk;
  logic       run;
  logic       trap_q, irq_q, mret_q, mstatus_q, mie_q, mcause_q, rf_q;

  // Sequencer: grant in IDLE, step the pass counter in RUN, ack in DONE.
  // Pass flags are latched at grant and left alone until the next grant;
  // they only reach the outputs through the RUN/DONE gating below.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      cnt       <= 5'd0;
      trap_q    <= 1'b0;
      irq_q     <= 1'b0;
      mret_q    <= 1'b0;
      mstatus_q <= 1'b0;
      mie_q     <= 1'b0;
      mcause_q  <= 1'b0;
      rf_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= 5'd0;
          if (i_trap_req || i_irq_pending) begin
            state     <= RUN;
            trap_q    <= 1'b1;
            irq_q     <= !i_trap_req;
            mret_q    <= 1'b0;
            mstatus_q <= 1'b1;
            mie_q     <= 1'b0;
            mcause_q  <= 1'b1;
            rf_q      <= 1'b1;
          end else if (i_csr_req) begin
            state     <= RUN;
            trap_q    <= 1'b0;
            irq_q     <= 1'b0;
            mret_q    <= i_mret;
            mstatus_q <= i_mret || (i_csr_sel == 2'd0);
            mie_q     <= !i_mret && (i_csr_sel == 2'd1);
            mcause_q  <= !i_mret && (i_csr_sel == 2'd2);
            rf_q      <= !i_mret && (i_csr_sel == 2'd3);
          end
        end
        RUN: begin
          cnt <= cnt + STEP;
          if (cnt == LAST) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Output decode from the registered state, counter and pass flags.
  always_comb begin
    run          = (state == RUN);
    cnt_blk      = cnt >> SH;
    o_busy       = (state != IDLE);
    o_en         = run;
    o_trap_ack   = (state == DONE) && trap_q;
    o_csr_ack    = (state == DONE) && !trap_q;
    o_cnt0to3    = run && (cnt < 5'd4);
    o_cnt3       = run && (cnt_blk == B3);
    o_cnt7       = run && (cnt_blk == B7);
    o_cnt11      = run && (cnt_blk == B11);
    o_cnt12      = run && (cnt_blk == B12);
    o_cnt_done   = run && (cnt == LAST);
    o_mstatus_en = run && mstatus_q;
    o_mie_en     = run && mie_q;
    o_mcause_en  = run && mcause_q;
    o_rf_csr_en  = run && rf_q;
    o_trap       = run && trap_q;
    o_irq        = run && irq_q;
    o_mret       = run && mret_q;
  end

endmodule
